// File: rtl/colocviu_pkg.sv
// Shared types and default sizing for the colocviu lab sequencers and monitors.
// Pure declarations: no logic, no latency, no flow control.
package colocviu_pkg;

  localparam int PAT_W_DEF  = 16;
  localparam int LEN_W_DEF  = 5;
  localparam int REP_W_DEF  = 8;
  localparam int DRAIN_DEF  = 3;
  localparam int ONES_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle update latency; no backpressure, it simply sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/colocviu_seq_ctrl.sv
// Serial stimulus sequencer + ones monitor: first bit one cycle after start, done after len*reps+DRAIN+1.
// No backpressure: start is only honoured between runs, a held start chains runs back-to-back.
module colocviu_seq_ctrl
  import colocviu_pkg::*;
#(
  parameter int PAT_W  = PAT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int REP_W  = REP_W_DEF,
  parameter int DRAIN  = DRAIN_DEF,
  parameter int ONES_W = ONES_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [LEN_W-1:0]  len,
  input  logic [REP_W-1:0]  reps,
  input  logic              q_in,
  output logic              a_out,
  output logic              busy,
  output logic              done,
  output logic [ONES_W-1:0] ones_cnt
);

  localparam int DRN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d, bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] reps_q, reps_d, rep_idx_q, rep_idx_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             a_out_q, a_out_d;
  logic             cnt_clr;
  logic             args_ok;

  assign args_ok = (len != '0) && (len <= LEN_W'(PAT_W)) && (reps != '0);

  // DONE also samples start so a held start restarts with no idle gap.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sh_d      = sh_q;
    len_d     = len_q;
    reps_d    = reps_q;
    bit_idx_d = bit_idx_q;
    rep_idx_d = rep_idx_q;
    drn_d     = drn_q;
    a_out_d   = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_clr = 1'b1;
          if (args_ok) begin
            pat_d     = pattern;
            sh_d      = pattern >> 1;
            len_d     = len;
            reps_d    = reps;
            bit_idx_d = '0;
            rep_idx_d = '0;
            a_out_d   = pattern[0];
            state_d   = ST_SHIFT;
          end else begin
            state_d   = ST_DONE;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // sh_q holds the not-yet-sent bits of the current pass, next one in bit 0.
        if (bit_idx_q == len_q - LEN_W'(1)) begin
          bit_idx_d = '0;
          if (rep_idx_q != reps_q - REP_W'(1)) begin
            rep_idx_d = rep_idx_q + REP_W'(1);
            a_out_d   = pat_q[0];
            sh_d      = pat_q >> 1;
          end else begin
            drn_d   = '0;
            state_d = ST_DRAIN;
          end
        end else begin
          bit_idx_d = bit_idx_q + LEN_W'(1);
          a_out_d   = sh_q[0];
          sh_d      = sh_q >> 1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == DRN_W'(DRAIN - 1)) begin
          state_d = ST_DONE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      bit_idx_q <= '0;
      rep_idx_q <= '0;
      drn_q     <= '0;
      a_out_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      bit_idx_q <= bit_idx_d;
      rep_idx_q <= rep_idx_d;
      drn_q     <= drn_d;
      a_out_q   <= a_out_d;
    end
  end

  assign a_out = a_out_q;
  assign busy  = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign done  = (state_q == ST_DONE);

  sat_counter #(
    .W (ONES_W)
  ) u_ones_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (busy & q_in),
    .cnt (ones_cnt)
  );

endmodule

// File: tb/tb_colocviu_seq_ctrl.sv
// Directed bench for colocviu_seq_ctrl; a second instance with a 4-bit ones counter
// shares the stimulus and is checked only for saturation and drain capture.
module tb_colocviu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [7:0]  reps = '0;
  logic        q_in = 1'b0;
  logic        a_out, busy, done;
  logic [15:0] ones_cnt;
  logic        a_out2, busy2, done2;
  logic [3:0]  ones2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  colocviu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .q_in(q_in), .a_out(a_out), .busy(busy), .done(done), .ones_cnt(ones_cnt)
  );

  colocviu_seq_ctrl #(.ONES_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .q_in(q_in), .a_out(a_out2), .busy(busy2), .done(done2), .ones_cnt(ones2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    n_chk++;
    if ({a_out, busy, done, ones_cnt} !== 19'd0)
      $display("FAIL reset_outputs: a_out=%b busy=%b done=%b ones=%0d, want all 0", a_out, busy, done, ones_cnt);
    else n_pass++;
  endtask

  // pattern 0b101, len 3, reps 2; inputs scribbled right after start to show they are latched
  task automatic test_basic();
    logic [6:1] ea;
    ea = 6'b101101;
    pattern = 16'h0005; len = 5'd3; reps = 8'd2; q_in = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; pattern = 16'hFFFF; len = 5'd7; reps = 8'd9;
    for (int c = 1; c <= 10; c++) begin
      n_chk++;
      if (a_out !== ((c <= 6) ? ea[c] : 1'b0) || busy !== (c <= 9) || done !== (c == 10))
        $display("FAIL basic_c%0d: a_out=%b busy=%b done=%b, want %b %b %b", c, a_out, busy, done,
                 (c <= 6) ? ea[c] : 1'b0, c <= 9, c == 10);
      else n_pass++;
      if (c == 10) begin
        n_chk++;
        if (ones_cnt !== 16'd9) $display("FAIL basic_ones: got %0d want 9", ones_cnt);
        else n_pass++;
      end
      if (c < 10) cyc();
    end
    cyc();
    q_in = 1'b0;
    cyc();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || ones_cnt !== 16'd9)
      $display("FAIL basic_idle_hold: done=%b busy=%b ones=%0d, want 0 0 9", done, busy, ones_cnt);
    else n_pass++;
  endtask

  // q_in replays the expected a_out three cycles late
  task automatic test_drain_capture();
    logic [6:1] ea;
    ea = 6'b101101;
    pattern = 16'h0005; len = 5'd3; reps = 8'd2; q_in = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      q_in = (c >= 4 && c <= 9) ? ea[c-3] : 1'b0;
      if (c < 10) cyc();
    end
    n_chk++;
    if (done !== 1'b1 || ones_cnt !== 16'd4 || ones2 !== 4'd4)
      $display("FAIL drain_capture: done=%b ones=%0d ones_w4=%0d, want 1 4 4", done, ones_cnt, ones2);
    else n_pass++;
    q_in = 1'b0;
    cyc();
  endtask

  task automatic test_invalid(input logic [4:0] l, input logic [7:0] r);
    pattern = 16'hFFFF; len = l; reps = r; q_in = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || a_out !== 1'b0 || ones_cnt !== 16'd0)
      $display("FAIL invalid_len%0d_reps%0d_c1: done=%b busy=%b a_out=%b ones=%0d, want 1 0 0 0",
               l, r, done, busy, a_out, ones_cnt);
    else n_pass++;
    cyc();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || a_out !== 1'b0 || ones_cnt !== 16'd0)
      $display("FAIL invalid_len%0d_reps%0d_c2: done=%b busy=%b a_out=%b ones=%0d, want 0 0 0 0",
               l, r, done, busy, a_out, ones_cnt);
    else n_pass++;
    q_in = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int dones;
    logic [3:1] ea;
    pattern = 16'hFFFF; len = 5'd16; reps = 8'd4; q_in = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    n_chk++;
    if (busy !== 1'b1 || a_out !== 1'b1 || ones_cnt !== 16'd3)
      $display("FAIL midrun_pre: busy=%b a_out=%b ones=%0d, want 1 1 3", busy, a_out, ones_cnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({a_out, busy, done, ones_cnt} !== 19'd0)
      $display("FAIL midrun_rst: a_out=%b busy=%b done=%b ones=%0d, want all 0", a_out, busy, done, ones_cnt);
    else n_pass++;
    cyc();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      cyc();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_chk++;
    if (dones !== 0) $display("FAIL midrun_no_done: %0d active cycles after abort, want 0", dones);
    else n_pass++;
    ea = 3'b101;
    pattern = 16'h0005; len = 5'd3; reps = 8'd1; q_in = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_chk++;
      if (a_out !== ((c <= 3) ? ea[c] : 1'b0) || busy !== (c <= 6) || done !== (c == 7))
        $display("FAIL restart_c%0d: a_out=%b busy=%b done=%b, want %b %b %b", c, a_out, busy, done,
                 (c <= 3) ? ea[c] : 1'b0, c <= 6, c == 7);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_saturate();
    int done_at;
    pattern = 16'h1234; len = 5'd16; reps = 8'd2; q_in = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 100 && done_at < 0; c++) begin
      if (done === 1'b1) done_at = c;
      else cyc();
    end
    n_chk++;
    if (done_at !== 36) $display("FAIL sat_done_cycle: got %0d want 36", done_at);
    else n_pass++;
    n_chk++;
    if (ones_cnt !== 16'd35 || ones2 !== 4'd15)
      $display("FAIL sat_ones: ones16=%0d ones4=%0d, want 35 15", ones_cnt, ones2);
    else n_pass++;
    q_in = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int p;
    pattern = 16'h0001; len = 5'd2; reps = 8'd1; q_in = 1'b0; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      p = c % 6;
      n_chk++;
      if (done !== (p == 0) || busy !== (p >= 1 && p <= 5) || a_out !== (p == 1))
        $display("FAIL b2b_c%0d: done=%b busy=%b a_out=%b, want %b %b %b", c, done, busy, a_out,
                 p == 0, p >= 1 && p <= 5, p == 1);
      else n_pass++;
    end
    start = 1'b0;
    repeat (10) cyc();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_stop: done=%b busy=%b, want 0 0", done, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain_capture();
    test_invalid(5'd0, 8'd2);
    test_invalid(5'd17, 8'd1);
    test_invalid(5'd3, 8'd0);
    test_reset_midrun();
    test_saturate();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
